// File: rtl/cu_motion.sv
// Control unit for the dp_motion ball datapath: serve, per-frame update/alter/collide
// passes, frame waiting, scoring and game over. Optional rally speed-up: RALLY_SPEEDUP_EN.
module cu_motion #(
   parameter int WIN_SCORE = 11,
   parameter int SCORE_W   = 4,
   parameter int SERVE_GAP = 2
) (
   input  logic               clk_1,
   input  logic               rst,
   input  logic               start,
   input  logic               flag,
   input  logic               collide,
   input  logic [1:0]         edg,
   output logic               Initial_ball,
   output logic               Activate_cntr,
   output logic               Compute_alter,
   output logic               Compute_collide,
   output logic               Value_select,
   output logic [SCORE_W-1:0] score_l,
   output logic [SCORE_W-1:0] score_r,
   output logic               game_over,
   output logic               winner,
   output logic [1:0]         speed_level
);

   localparam logic [SCORE_W-1:0] WIN_V = SCORE_W'(WIN_SCORE);
   localparam int                 GAP_W = (SERVE_GAP > 1) ? $clog2(SERVE_GAP) : 1;
   localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(SERVE_GAP - 1);

   generate
      if (WIN_SCORE < 1 || WIN_SCORE >= (1 << SCORE_W)) begin : g_bad_win_score
         $error("cu_motion: WIN_SCORE must be in 1 .. 2**SCORE_W-1");
      end
      if (SERVE_GAP < 1) begin : g_bad_serve_gap
         $error("cu_motion: SERVE_GAP must be at least 1");
      end
   endgenerate

   typedef enum logic [3:0] {
      S_IDLE,
      S_INIT,
      S_UPDATE,
      S_ALTER,
      S_CHECK,
      S_DECIDE,
      S_WAIT,
      S_SCORE,
      S_SERVE,
      S_OVER
   } state_t;

   state_t             state;
   state_t             next_state;
   logic               first_pass;
   logic               point_right;
   logic [GAP_W-1:0]   gap_cnt;
   logic [SCORE_W-1:0] score_next;
   logic               win_reached;
   logic               edge_miss;

   // A miss is only counted when the ball left through the left or right edge.
   assign edge_miss   = edg[1];
   assign score_next  = (point_right ? score_r : score_l) + SCORE_W'(1);
   assign win_reached = (score_next == WIN_V);

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (start) next_state = S_INIT;
         S_INIT:   next_state = S_UPDATE;
         S_UPDATE: next_state = S_ALTER;
         S_ALTER:  next_state = S_CHECK;
         S_CHECK:  next_state = S_DECIDE;
         S_DECIDE: begin
            if (collide)        next_state = S_WAIT;
            else if (edge_miss) next_state = S_SCORE;
            else                next_state = S_WAIT;
         end
         S_WAIT:   if (flag) next_state = S_UPDATE;
         S_SCORE:  next_state = win_reached ? S_OVER : S_SERVE;
         S_SERVE:  if (flag && (gap_cnt == GAP_LAST)) next_state = S_INIT;
         S_OVER:   if (start) next_state = S_INIT;
         default:  next_state = S_IDLE;
      endcase
   end

   always_comb begin
      Initial_ball    = 1'b0;
      Activate_cntr   = 1'b0;
      Compute_alter   = 1'b0;
      Compute_collide = 1'b0;
      game_over       = 1'b0;
      case (state)
         S_INIT:  Initial_ball    = 1'b1;
         S_ALTER: Compute_alter   = 1'b1;
         S_CHECK: Compute_collide = 1'b1;
         S_WAIT:  Activate_cntr   = 1'b1;
         S_SERVE: Activate_cntr   = 1'b1;
         S_OVER:  game_over       = 1'b1;
         default: ;
      endcase
   end

   assign Value_select = ~first_pass;

   always_ff @(posedge clk_1) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // first_pass tracks the state being entered so Value_select is already 0 during
   // INIT and already 1 during the first CHECK.
   always_ff @(posedge clk_1) begin
      if (rst) begin
         first_pass <= 1'b1;
      end else if (next_state == S_INIT) begin
         first_pass <= 1'b1;
      end else if (next_state == S_CHECK) begin
         first_pass <= 1'b0;
      end
   end

   always_ff @(posedge clk_1) begin
      if (rst) begin
         point_right <= 1'b0;
         score_l     <= '0;
         score_r     <= '0;
         winner      <= 1'b0;
      end else begin
         if (state == S_DECIDE) begin
            point_right <= (edg == 2'b10);
         end
         if (state == S_SCORE) begin
            if (point_right) score_r <= score_next;
            else             score_l <= score_next;
            if (win_reached) winner <= point_right;
         end
         if ((state == S_OVER) && start) begin
            score_l <= '0;
            score_r <= '0;
         end
      end
   end

   always_ff @(posedge clk_1) begin
      if (rst) begin
         gap_cnt <= '0;
      end else if (state != S_SERVE) begin
         gap_cnt <= '0;
      end else if (flag) begin
         gap_cnt <= gap_cnt + GAP_W'(1);
      end
   end

`ifdef RALLY_SPEEDUP_EN
   logic [1:0] hit_cnt;
   logic [1:0] speed_q;

   // Every fourth paddle hit (hit counter wrapping) raises the speed hint, up to 3.
   always_ff @(posedge clk_1) begin
      if (rst) begin
         hit_cnt <= 2'd0;
         speed_q <= 2'd0;
      end else if ((state == S_INIT) || ((state == S_OVER) && start)) begin
         hit_cnt <= 2'd0;
         speed_q <= 2'd0;
      end else if ((state == S_DECIDE) && collide) begin
         hit_cnt <= hit_cnt + 2'd1;
         if ((hit_cnt == 2'd3) && (speed_q != 2'd3)) begin
            speed_q <= speed_q + 2'd1;
         end
      end
   end

   assign speed_level = speed_q;
`else
   assign speed_level = 2'b00;
`endif

endmodule

// File: tb/tb_cu_motion.sv
// Self-checking bench for cu_motion: directed scenarios plus a randomized rally
// checked against a score/speed model kept in plain integers.
module tb_cu_motion;

   localparam int WIN_SCORE = 11;
   localparam int SCORE_W   = 4;
   localparam int SERVE_GAP = 2;
`ifdef RALLY_SPEEDUP_EN
   localparam bit SPEED_EN = 1'b1;
`else
   localparam bit SPEED_EN = 1'b0;
`endif

   // Control vector: {Initial_ball, Activate_cntr, Compute_alter, Compute_collide, Value_select, game_over}
   localparam logic [5:0] C_IDLE  = 6'b000000;
   localparam logic [5:0] C_INIT  = 6'b100000;
   localparam logic [5:0] C_UPD0  = 6'b000000;
   localparam logic [5:0] C_ALT0  = 6'b001000;
   localparam logic [5:0] C_UPD1  = 6'b000010;
   localparam logic [5:0] C_ALT1  = 6'b001010;
   localparam logic [5:0] C_CHK   = 6'b000110;
   localparam logic [5:0] C_DEC   = 6'b000010;
   localparam logic [5:0] C_WAIT  = 6'b010010;
   localparam logic [5:0] C_SCORE = 6'b000010;
   localparam logic [5:0] C_SERVE = 6'b010010;
   localparam logic [5:0] C_OVER  = 6'b000011;
   localparam logic [3:0][5:0] P_FIRST = {C_DEC, C_CHK, C_ALT0, C_UPD0};
   localparam logic [3:0][5:0] P_NEXT  = {C_DEC, C_CHK, C_ALT1, C_UPD1};

   logic clk_1 = 1'b0;
   logic rst, start, flag, collide;
   logic [1:0] edg;
   logic Initial_ball, Activate_cntr, Compute_alter, Compute_collide, Value_select;
   logic [SCORE_W-1:0] score_l, score_r;
   logic game_over, winner;
   logic [1:0] speed_level;
   wire  [5:0] ctrl = {Initial_ball, Activate_cntr, Compute_alter, Compute_collide,
                       Value_select, game_over};

   int checks = 0;
   int errors = 0;
   logic [2*SCORE_W-1:0] exp_q[$];

   cu_motion #(.WIN_SCORE(WIN_SCORE), .SCORE_W(SCORE_W), .SERVE_GAP(SERVE_GAP)) dut (
      .clk_1(clk_1), .rst(rst), .start(start), .flag(flag), .collide(collide), .edg(edg),
      .Initial_ball(Initial_ball), .Activate_cntr(Activate_cntr),
      .Compute_alter(Compute_alter), .Compute_collide(Compute_collide),
      .Value_select(Value_select), .score_l(score_l), .score_r(score_r),
      .game_over(game_over), .winner(winner), .speed_level(speed_level)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk_1 = ~clk_1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // ---------------- model ----------------
   function automatic logic [1:0] model_speed(input int hits);
      if (!SPEED_EN) return 2'd0;
      if (hits / 4 >= 3) return 2'd3;
      return 2'(hits / 4);
   endfunction

   // ---------------- drivers (no checking) ----------------
   // Outputs are observed and inputs changed 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk_1);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Entry at UPDATE; returns observed controls UPDATE..DECIDE, exits one cycle after DECIDE.
   task automatic drive_pass(input logic coll, input logic [1:0] e,
                             output logic [3:0][5:0] seen);
      seen[0] = ctrl; tick();
      seen[1] = ctrl; tick();
      seen[2] = ctrl; tick();
      seen[3] = ctrl;
      collide = coll;
      edg     = e;
      tick();
      collide = 1'b0;
      edg     = 2'b00;
   endtask

   // Entry in WAIT; idles n cycles, pulses flag, exits in UPDATE.
   task automatic wait_then_flag(input int n);
      repeat (n) tick();
      flag = 1'b1;
      tick();
      flag = 1'b0;
   endtask

   // Entry in SERVE; separated flag pulses, exits in INIT.
   task automatic serve_flags();
      for (int g = 0; g < SERVE_GAP; g++) begin
         if (g > 0) tick();
         flag = 1'b1;
         tick();
         flag = 1'b0;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; start = 1'b0; flag = 1'b0; collide = 1'b0; edg = 2'b00;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      checks++;
      if (ctrl !== C_IDLE) begin errors++; $display("FAIL reset_ctrl got %b want %b", ctrl, C_IDLE); end
      checks++;
      if ({score_l, score_r, winner, speed_level} !== '0) begin
         errors++; $display("FAIL reset_status got l=%0d r=%0d w=%b s=%0d want all 0",
                            score_l, score_r, winner, speed_level);
      end
      flag = 1'b1; tick(); flag = 1'b0; tick();
      checks++;
      if (ctrl !== C_IDLE) begin errors++; $display("FAIL idle_ignores_flag got %b want %b", ctrl, C_IDLE); end
   endtask

   task automatic test_start_sequence();
      pulse_start();
      checks++;
      if (ctrl !== C_INIT) begin errors++; $display("FAIL start_init got %b want %b", ctrl, C_INIT); end
      tick();
      checks++;
      if (ctrl !== C_UPD0) begin errors++; $display("FAIL first_update got %b want %b", ctrl, C_UPD0); end
      tick();
      checks++;
      if (ctrl !== C_ALT0) begin errors++; $display("FAIL first_alter got %b want %b", ctrl, C_ALT0); end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (ctrl !== C_CHK) begin errors++; $display("FAIL first_check got %b want %b", ctrl, C_CHK); end
      tick();
      checks++;
      if (ctrl !== C_DEC) begin errors++; $display("FAIL first_decide got %b want %b", ctrl, C_DEC); end
      collide = 1'b1;
      tick();
      collide = 1'b0;
      checks++;
      if (ctrl !== C_WAIT) begin errors++; $display("FAIL collide_to_wait got %b want %b", ctrl, C_WAIT); end
   endtask

   task automatic test_wait_hold();
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (ctrl !== C_WAIT) begin errors++; $display("FAIL wait_hold[%0d] got %b want %b", i, ctrl, C_WAIT); end
         tick();
      end
      flag = 1'b1;
      tick();
      flag = 1'b0;
      checks++;
      if (ctrl !== C_UPD1) begin errors++; $display("FAIL flag_to_update got %b want %b", ctrl, C_UPD1); end
      tick();
      checks++;
      if (ctrl !== C_ALT1) begin errors++; $display("FAIL alter_after_flag got %b want %b", ctrl, C_ALT1); end
      tick();
      tick();
      checks++;
      if (ctrl !== C_DEC) begin errors++; $display("FAIL second_decide got %b want %b", ctrl, C_DEC); end
   endtask

   task automatic test_collide_priority();
      collide = 1'b1;
      edg     = 2'b11;
      tick();
      collide = 1'b0;
      edg     = 2'b00;
      checks++;
      if (ctrl !== C_WAIT) begin errors++; $display("FAIL priority_state got %b want %b", ctrl, C_WAIT); end
      tick();
      checks++;
      if ({score_l, score_r} !== '0) begin
         errors++; $display("FAIL priority_score got l=%0d r=%0d want 0 0", score_l, score_r);
      end
   endtask

   task automatic test_score_right();
      logic [3:0][5:0] seen;
      wait_then_flag(2);
      drive_pass(1'b0, 2'b10, seen);
      checks++;
      if (seen !== P_NEXT) begin errors++; $display("FAIL score_pass got %h want %h", seen, P_NEXT); end
      checks++;
      if (ctrl !== C_SCORE || score_r !== 0) begin
         errors++; $display("FAIL score_state got %b r=%0d want %b r=0", ctrl, score_r, C_SCORE);
      end
      tick();
      checks++;
      if (ctrl !== C_SERVE || score_r !== 1 || score_l !== 0) begin
         errors++; $display("FAIL score_right got %b l=%0d r=%0d want %b l=0 r=1",
                            ctrl, score_l, score_r, C_SERVE);
      end
      for (int g = 0; g < SERVE_GAP; g++) begin
         flag = 1'b1;
         tick();
         flag = 1'b0;
         if (g < SERVE_GAP - 1) begin
            tick();
            checks++;
            if (ctrl !== C_SERVE) begin errors++; $display("FAIL serve_gap[%0d] got %b want %b", g, ctrl, C_SERVE); end
         end
      end
      checks++;
      if (ctrl !== C_INIT) begin errors++; $display("FAIL reserve_init got %b want %b", ctrl, C_INIT); end
      tick();
      drive_pass(1'b1, 2'b00, seen);
      checks++;
      if (seen !== P_FIRST) begin errors++; $display("FAIL reserve_pass got %h want %h", seen, P_FIRST); end
   endtask

   task automatic test_reset_mid();
      wait_then_flag(0);
      tick();
      checks++;
      if (ctrl !== C_ALT1) begin errors++; $display("FAIL mid_alter got %b want %b", ctrl, C_ALT1); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (ctrl !== C_IDLE || {score_l, score_r, winner, speed_level} !== '0) begin
         errors++; $display("FAIL mid_reset got %b l=%0d r=%0d want %b l=0 r=0",
                            ctrl, score_l, score_r, C_IDLE);
      end
      tick();
      checks++;
      if (ctrl !== C_IDLE) begin errors++; $display("FAIL mid_reset_idle got %b want %b", ctrl, C_IDLE); end
   endtask

   task automatic test_game_over();
      logic [3:0][5:0] seen;
      pulse_start();
      tick();
      for (int p = 1; p <= WIN_SCORE; p++) begin
         drive_pass(1'b0, 2'b11, seen);
         checks++;
         if (seen !== (p == 1 ? P_FIRST : P_FIRST)) begin
            errors++; $display("FAIL go_pass[%0d] got %h want %h", p, seen, P_FIRST);
         end
         tick();
         checks++;
         if (score_l !== SCORE_W'(p) || score_r !== 0) begin
            errors++; $display("FAIL go_score[%0d] got l=%0d r=%0d want l=%0d r=0", p, score_l, score_r, p);
         end
         if (p < WIN_SCORE) begin
            serve_flags();
            tick();
         end
      end
      checks++;
      if (ctrl !== C_OVER || winner !== 1'b0) begin
         errors++; $display("FAIL go_over got %b w=%b want %b w=0", ctrl, winner, C_OVER);
      end
      flag = 1'b1; tick(); flag = 1'b0; tick();
      checks++;
      if (ctrl !== C_OVER) begin errors++; $display("FAIL over_hold got %b want %b", ctrl, C_OVER); end
      pulse_start();
      checks++;
      if (ctrl !== C_INIT || {score_l, score_r} !== '0) begin
         errors++; $display("FAIL restart got %b l=%0d r=%0d want %b l=0 r=0",
                            ctrl, score_l, score_r, C_INIT);
      end
   endtask

   task automatic test_random_rally();
      logic [3:0][5:0] seen;
      logic coll;
      logic [1:0] e;
      logic first_p = 1'b1;
      logic done = 1'b0;
      int m_l = 0, m_r = 0, m_hits = 0;
      tick();
      for (int pass = 0; pass < 600 && !done; pass++) begin
         coll = ($urandom_range(0, 3) == 0);
         e    = 2'($urandom_range(0, 3));
         drive_pass(coll, e, seen);
         checks++;
         if (seen !== (first_p ? P_FIRST : P_NEXT)) begin
            errors++; $display("FAIL rally_pass[%0d] got %h want %h", pass, seen, first_p ? P_FIRST : P_NEXT);
         end
         first_p = 1'b0;
         if (coll || e == 2'b00 || e == 2'b01) begin
            if (coll) m_hits++;
            checks++;
            if (ctrl !== C_WAIT || speed_level !== model_speed(m_hits)) begin
               errors++; $display("FAIL rally_wait[%0d] got %b s=%0d want %b s=%0d",
                                  pass, ctrl, speed_level, C_WAIT, model_speed(m_hits));
            end
            wait_then_flag($urandom_range(0, 4));
         end else begin
            if (e == 2'b10) m_r++;
            else            m_l++;
            exp_q.push_back({SCORE_W'(m_l), SCORE_W'(m_r)});
            tick();
            checks++;
            if ({score_l, score_r} !== exp_q[0]) begin
               errors++; $display("FAIL rally_score[%0d] got %h want %h", pass, {score_l, score_r}, exp_q[0]);
            end
            void'(exp_q.pop_front());
            if (m_l == WIN_SCORE || m_r == WIN_SCORE) begin
               checks++;
               if (ctrl !== C_OVER || winner !== (m_r == WIN_SCORE)) begin
                  errors++; $display("FAIL rally_over got %b w=%b want %b w=%b",
                                     ctrl, winner, C_OVER, m_r == WIN_SCORE);
               end
               done = 1'b1;
            end else begin
               serve_flags();
               checks++;
               if (ctrl !== C_INIT) begin errors++; $display("FAIL rally_reserve got %b want %b", ctrl, C_INIT); end
               m_hits  = 0;
               first_p = 1'b1;
               tick();
            end
         end
      end
      checks++;
      if (!done) begin errors++; $display("FAIL rally_budget got no game over want game over"); end
   endtask

   task automatic test_speedup();
      logic [3:0][5:0] seen;
      pulse_start();
      checks++;
      if (speed_level !== 2'd0 || {score_l, score_r} !== '0) begin
         errors++; $display("FAIL speed_restart got s=%0d l=%0d r=%0d want 0 0 0", speed_level, score_l, score_r);
      end
      tick();
      for (int k = 1; k <= 20; k++) begin
         drive_pass(1'b1, 2'($urandom_range(0, 3)), seen);
         checks++;
         if (speed_level !== model_speed(k)) begin
            errors++; $display("FAIL speed_hits[%0d] got %0d want %0d", k, speed_level, model_speed(k));
         end
         wait_then_flag(0);
      end
      drive_pass(1'b0, 2'b11, seen);
      tick();
      checks++;
      if (ctrl !== C_SERVE || speed_level !== model_speed(20)) begin
         errors++; $display("FAIL speed_serve got %b s=%0d want %b s=%0d", ctrl, speed_level, C_SERVE, model_speed(20));
      end
      serve_flags();
      tick();
      checks++;
      if (speed_level !== 2'd0) begin errors++; $display("FAIL speed_clear got %0d want 0", speed_level); end
   endtask

   initial begin
      test_reset();
      test_start_sequence();
      test_wait_hold();
      test_collide_priority();
      test_score_right();
      test_reset_mid();
      test_game_over();
      test_random_rally();
      test_speedup();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
